// File: rtl/i2s_stream_arb.sv
// -----------------------------------------------------------------------------
// i2s_stream_arb
//   Packet-level round-robin arbiter. Merges CN per-channel AXI-Stream sources
//   into one registered output stream, forwarding each source packet (beats up
//   to and including tlast) atomically and tagging it with its channel index.
//
// Ports
//   mclki           clock (sole domain)
//   arst_n          asynchronous active-low reset
//   s_axis_tvalid   per-channel beat valid                      [CN]
//   s_axis_tready   per-channel ready, at most one bit high     [CN]
//   s_axis_tdata    channel c data at [DW*c +: DW]               [DW*CN]
//   s_axis_tlast    per-channel last beat of packet             [CN]
//   i_enable        arbitration mask; 0 = never granted anew    [CN]
//   m_axis_tvalid   merged output valid (registered)
//   m_axis_tready   downstream ready
//   m_axis_tdata    merged data (registered)                    [DW]
//   m_axis_tlast    merged last (registered)
//   m_axis_tid      source channel of the current beat          [IW]
//   o_busy          high while a packet is being forwarded
//   o_pkt_cnt       packets loaded into the output register     [32]
// -----------------------------------------------------------------------------
module i2s_stream_arb #(
  parameter int CN = 16,
  parameter int DW = 8,
  parameter int IW = 4
) (
  input  logic             mclki,
  input  logic             arst_n,
  input  logic [CN-1:0]    s_axis_tvalid,
  output logic [CN-1:0]    s_axis_tready,
  input  logic [DW*CN-1:0] s_axis_tdata,
  input  logic [CN-1:0]    s_axis_tlast,
  input  logic [CN-1:0]    i_enable,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DW-1:0]    m_axis_tdata,
  output logic             m_axis_tlast,
  output logic [IW-1:0]    m_axis_tid,
  output logic             o_busy,
  output logic [31:0]      o_pkt_cnt
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            tvalid_q, tvalid_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic            tlast_q, tlast_d;
  logic [IW-1:0]   tid_q, tid_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            load;
  logic [CN-1:0]   req;
  logic            src_vld;
  logic [DW-1:0]   src_data;
  logic            src_last;

  // First requesting channel strictly after ptr, wrapping modulo CN, so the
  // channel served last has the lowest priority on the next grant.
  function automatic logic [IW-1:0] rr_pick(input logic [CN-1:0] r,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= CN; i++) begin
      idx = (int'(ptr) + i) % CN;
      if (!found && r[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge mclki or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IW'(CN - 1);
      gnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tid_q    <= tid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    tid_d         = tid_q;
    cnt_d         = cnt_q;
    s_axis_tready = '0;

    // The output register may take a new beat when empty or being drained.
    load     = !tvalid_q || m_axis_tready;
    req      = s_axis_tvalid & i_enable;
    src_vld  = s_axis_tvalid[gnt_q];
    src_data = s_axis_tdata[DW*gnt_q +: DW];
    src_last = s_axis_tlast[gnt_q];

    // A drained beat leaves the register empty unless refilled below.
    if (load) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(req, ptr_q);
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Only the granted source sees ready; the mask is ignored mid-packet.
        s_axis_tready[gnt_q] = load;
        if (src_vld && load) begin
          tvalid_d = 1'b1;
          tdata_d  = src_data;
          tlast_d  = src_last;
          tid_d    = gnt_q;
          if (src_last) begin
            ptr_d   = gnt_q;
            state_d = ST_IDLE;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign o_busy        = (state_q == ST_ACTIVE);
  assign o_pkt_cnt     = cnt_q;

endmodule
